// File: rtl/render_scheduler.sv
// Frame-level sequencer for the ray-tracing renderer: raster-order coordinate
// issue with in-flight credit limiting, in-order result write-back to the
// framebuffer, and a per-frame scene-latch strobe.
module render_scheduler #(
    parameter int H_RES        = 320,
    parameter int V_RES        = 180,
    parameter int MAX_INFLIGHT = 384,
    parameter int ADDR_W       = 16
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              start,
    input  logic                              continuous,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              scene_latch,
    output logic [10:0]                       hcount_axis_tdata,
    output logic                              hcount_axis_tvalid,
    input  logic                              hcount_axis_tready,
    output logic [9:0]                        vcount_axis_tdata,
    output logic                              vcount_axis_tvalid,
    input  logic                              vcount_axis_tready,
    input  logic [23:0]                       pixel_axis_tdata,
    input  logic                              pixel_axis_tvalid,
    output logic                              pixel_axis_tready,
    input  logic [10:0]                       pix_hcount_in,
    input  logic [9:0]                        pix_vcount_in,
    output logic                              fb_we,
    output logic [ADDR_W-1:0]                 fb_addr,
    output logic [23:0]                       fb_wdata,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              seq_err
);

    localparam int                IW         = $clog2(MAX_INFLIGHT + 1);
    localparam logic [10:0]       X_LAST     = 11'(H_RES - 1);
    localparam logic [9:0]        Y_LAST     = 10'(V_RES - 1);
    localparam logic [IW-1:0]     CREDIT_MAX = IW'(MAX_INFLIGHT);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [2:0] {IDLE, LATCH, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [10:0]       issue_x;
    logic [9:0]        issue_y;
    logic [10:0]       exp_x;
    logic [9:0]        exp_y;
    logic [ADDR_W-1:0] exp_addr;
    logic              issue_fire;
    logic              result_ok;

    assign hcount_axis_tvalid = (state == ISSUE) && (inflight < CREDIT_MAX);
    assign vcount_axis_tvalid = hcount_axis_tvalid;
    assign hcount_axis_tdata  = issue_x;
    assign vcount_axis_tdata  = issue_y;
    assign pixel_axis_tready  = 1'b1;

    assign issue_fire = hcount_axis_tvalid & hcount_axis_tready & vcount_axis_tready;
    assign result_ok  = pixel_axis_tvalid && (inflight != '0);

    // Frame sequencing FSM with registered status strobes and the issue raster counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            scene_latch <= 1'b0;
            issue_x     <= '0;
            issue_y     <= '0;
        end else begin
            frame_done  <= 1'b0;
            scene_latch <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LATCH;
                        busy        <= 1'b1;
                        scene_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    issue_x <= '0;
                    issue_y <= '0;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (issue_fire) begin
                        if (issue_x == X_LAST) begin
                            issue_x <= '0;
                            if (issue_y == Y_LAST) begin
                                state <= DRAIN;
                            end else begin
                                issue_y <= issue_y + 10'd1;
                            end
                        end else begin
                            issue_x <= issue_x + 11'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (inflight == '0) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (continuous) begin
                        state       <= LATCH;
                        scene_latch <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Credit counter: issue adds, accepted result removes, both together hold
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inflight <= '0;
        end else begin
            case ({issue_fire, result_ok})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // In-order result write-back with tag checking and a sticky sequence-error flag
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
            exp_x    <= '0;
            exp_y    <= '0;
            exp_addr <= '0;
            seq_err  <= 1'b0;
        end else begin
            fb_we <= 1'b0;
            if (state == LATCH) begin
                exp_x    <= '0;
                exp_y    <= '0;
                exp_addr <= '0;
                seq_err  <= 1'b0;
            end
            // inflight is always zero in LATCH, so the advance below never races the clear
            if (pixel_axis_tvalid) begin
                if (inflight != '0) begin
                    fb_we    <= 1'b1;
                    fb_addr  <= exp_addr;
                    fb_wdata <= pixel_axis_tdata;
                    if ((pix_hcount_in != exp_x) || (pix_vcount_in != exp_y)) begin
                        seq_err <= 1'b1;
                    end
                    if (exp_x == X_LAST) begin
                        exp_x <= '0;
                        exp_y <= (exp_y == Y_LAST) ? '0 : exp_y + 10'd1;
                    end else begin
                        exp_x <= exp_x + 11'd1;
                    end
                    exp_addr <= (exp_addr == ADDR_LAST) ? '0 : exp_addr + ADDR_W'(1);
                end else begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Self-checking bench for render_scheduler on a 4x3 frame: two instances
// (credit limits 16 and 2) share one latency-programmable renderer model.
module tb_render_scheduler;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int NPIX = H * V;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic aresetn, start, continuous, sel;
    logic h_rdy = 1'b1, v_rdy = 1'b1;
    logic rand_rdy = 1'b0, bad_tag_en = 1'b0;
    int   lat = 5;

    logic        pix_valid = 1'b0;
    logic [23:0] pix_data  = '0;
    logic [10:0] pix_h     = '0;
    logic [9:0]  pix_v     = '0;

    logic a_busy, a_done, a_latch, a_htv, a_vtv, a_ptr, a_we, a_err;
    logic [10:0] a_hd;
    logic [9:0]  a_vd;
    logic [15:0] a_addr;
    logic [23:0] a_wd;
    logic [4:0]  a_infl;
    logic b_busy, b_done, b_latch, b_htv, b_vtv, b_ptr, b_we, b_err;
    logic [10:0] b_hd;
    logic [9:0]  b_vd;
    logic [15:0] b_addr;
    logic [23:0] b_wd;
    logic [1:0]  b_infl;

    render_scheduler #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(16), .ADDR_W(16)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .start(start & ~sel), .continuous(continuous),
        .busy(a_busy), .frame_done(a_done), .scene_latch(a_latch),
        .hcount_axis_tdata(a_hd), .hcount_axis_tvalid(a_htv), .hcount_axis_tready(h_rdy),
        .vcount_axis_tdata(a_vd), .vcount_axis_tvalid(a_vtv), .vcount_axis_tready(v_rdy),
        .pixel_axis_tdata(pix_data), .pixel_axis_tvalid(pix_valid & ~sel), .pixel_axis_tready(a_ptr),
        .pix_hcount_in(pix_h), .pix_vcount_in(pix_v),
        .fb_we(a_we), .fb_addr(a_addr), .fb_wdata(a_wd), .inflight(a_infl), .seq_err(a_err));

    render_scheduler #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(2), .ADDR_W(16)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .start(start & sel), .continuous(continuous),
        .busy(b_busy), .frame_done(b_done), .scene_latch(b_latch),
        .hcount_axis_tdata(b_hd), .hcount_axis_tvalid(b_htv), .hcount_axis_tready(h_rdy),
        .vcount_axis_tdata(b_vd), .vcount_axis_tvalid(b_vtv), .vcount_axis_tready(v_rdy),
        .pixel_axis_tdata(pix_data), .pixel_axis_tvalid(pix_valid & sel), .pixel_axis_tready(b_ptr),
        .pix_hcount_in(pix_h), .pix_vcount_in(pix_v),
        .fb_we(b_we), .fb_addr(b_addr), .fb_wdata(b_wd), .inflight(b_infl), .seq_err(b_err));

    // View of whichever instance is currently under test
    logic s_busy, s_done, s_latch, s_htv, s_vtv, s_ptr, s_we, s_err;
    logic [10:0] s_hd;
    logic [9:0]  s_vd;
    logic [15:0] s_addr;
    logic [23:0] s_wd;
    int          s_infl;
    assign s_busy  = sel ? b_busy  : a_busy;
    assign s_done  = sel ? b_done  : a_done;
    assign s_latch = sel ? b_latch : a_latch;
    assign s_htv   = sel ? b_htv   : a_htv;
    assign s_vtv   = sel ? b_vtv   : a_vtv;
    assign s_ptr   = sel ? b_ptr   : a_ptr;
    assign s_we    = sel ? b_we    : a_we;
    assign s_err   = sel ? b_err   : a_err;
    assign s_hd    = sel ? b_hd    : a_hd;
    assign s_vd    = sel ? b_vd    : a_vd;
    assign s_addr  = sel ? b_addr  : a_addr;
    assign s_wd    = sel ? b_wd    : a_wd;
    assign s_infl  = sel ? int'(b_infl) : int'(a_infl);

    int n_chk = 0, n_fail = 0;
    int wr_cnt = 0, done_cnt = 0, latch_cnt = 0, peak = 0, iss_cnt = 0, pc = 0;
    logic prev_done = 1'b0, cont_seen = 1'b0, hold_pend = 1'b0;
    logic [10:0] held_h = '0;
    logic [9:0]  held_v = '0;

    typedef struct { int due; logic [10:0] x; logic [9:0] y; } job_t;
    job_t q[$];

    typedef struct {
        logic s; int l; logic rr; logic cont; int frames;
        int exp_writes; int exp_done; int exp_peak; logic exact;
    } row_t;
    row_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     64'(s_busy),  64'(0));
        check({tag, "_done"},     64'(s_done),  64'(0));
        check({tag, "_latch"},    64'(s_latch), 64'(0));
        check({tag, "_htvalid"},  64'(s_htv),   64'(0));
        check({tag, "_vtvalid"},  64'(s_vtv),   64'(0));
        check({tag, "_fb_we"},    64'(s_we),    64'(0));
        check({tag, "_seq_err"},  64'(s_err),   64'(0));
        check({tag, "_htdata"},   64'(s_hd),    64'(0));
        check({tag, "_vtdata"},   64'(s_vd),    64'(0));
        check({tag, "_fb_addr"},  64'(s_addr),  64'(0));
        check({tag, "_fb_wdata"}, 64'(s_wd),    64'(0));
        check({tag, "_inflight"}, 64'(s_infl),  64'(0));
        check({tag, "_ptready"},  64'(s_ptr),   64'(1));
    endtask

    // Issue monitor: records transfers into the renderer model, checks raster order and tdata hold
    always @(posedge aclk) begin
        if (aresetn) begin
            if (hold_pend) begin
                check("hold_h", 64'(s_hd), 64'(held_h));
                check("hold_v", 64'(s_vd), 64'(held_v));
                check("hold_valid", 64'(s_htv), 64'(1));
            end
            if (sel && b_infl == 2'd2) check("cap_blocks_issue", 64'(b_htv), 64'(0));
            if (s_htv && h_rdy && v_rdy) begin
                q.push_back('{pc + lat, s_hd, s_vd});
                check("issue_x", 64'(s_hd), 64'(iss_cnt % H));
                check("issue_y", 64'(s_vd), 64'((iss_cnt / H) % V));
                iss_cnt++;
            end
            hold_pend = s_htv && !(h_rdy && v_rdy);
            held_h    = s_hd;
            held_v    = s_vd;
        end else begin
            hold_pend = 1'b0;
        end
        pc++;
    end

    // Renderer model output plus write-port, strobe and credit observation
    always @(negedge aclk) begin
        h_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        v_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!aresetn) begin
            q.delete();
            pix_valid = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (pix_valid) void'(q.pop_front());
            pix_valid = 1'b0;
            if (q.size() > 0 && q[0].due <= pc) begin
                pix_valid = 1'b1;
                pix_data  = {8'hC0, 8'(q[0].y), 8'(q[0].x)};
                pix_h     = (bad_tag_en && q[0].x == 11'd1 && q[0].y == 10'd0) ? 11'd2 : q[0].x;
                pix_v     = q[0].y;
            end
            if (s_we) begin
                check("fb_addr", 64'(s_addr), 64'(wr_cnt % NPIX));
                check("fb_wdata", 64'(s_wd), 64'({8'hC0, 8'((wr_cnt % NPIX) / H), 8'(wr_cnt % H)}));
                wr_cnt++;
            end
            if (prev_done) begin
                if (cont_seen) check("relatch_after_done", 64'(s_latch), 64'(1));
                else           check("idle_after_done", 64'(s_busy), 64'(0));
            end
            if (s_done)  done_cnt++;
            if (s_latch) latch_cnt++;
            if (s_infl > peak) peak = s_infl;
            prev_done = s_done;
            cont_seen = continuous;
        end
    end

    task automatic clear_counts();
        wr_cnt = 0; done_cnt = 0; latch_cnt = 0; peak = 0; iss_cnt = 0;
    endtask

    task automatic run_frame(input logic s, input int l, input logic rr, input logic cont, input int frames);
        @(posedge aclk); #1;
        sel = s; lat = l; rand_rdy = rr; continuous = cont;
        clear_counts();
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        check("latch_cycle1", 64'(s_latch), 64'(1));
        check("tvalid_cycle1", 64'(s_htv), 64'(0));
        check("busy_cycle1", 64'(s_busy), 64'(1));
        @(posedge aclk); #1;
        check("latch_cycle2", 64'(s_latch), 64'(0));
        check("tvalid_cycle2", 64'(s_htv), 64'(1));
        check("tdata_cycle2", 64'({s_hd, s_vd}), 64'(0));
        check("seq_err_cycle2", 64'(s_err), 64'(0));
        for (int i = 0; i < 3000 && !(done_cnt >= frames && !s_busy); i++) begin
            @(posedge aclk); #1;
            if (cont && done_cnt >= 1) continuous = 1'b0;
        end
        check("frames_completed", 64'(done_cnt), 64'(frames));
        rand_rdy = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 5,  1'b0, 1'b0, 1, 12, 1, 5,  1'b1};
        tbl[1] = '{1'b1, 10, 1'b0, 1'b0, 1, 12, 1, 2,  1'b1};
        tbl[2] = '{1'b0, 5,  1'b1, 1'b0, 1, 12, 1, 16, 1'b0};
        tbl[3] = '{1'b1, 3,  1'b1, 1'b0, 1, 12, 1, 2,  1'b0};
        tbl[4] = '{1'b0, 5,  1'b0, 1'b1, 2, 24, 2, 5,  1'b1};

        aresetn = 1'b0; start = 1'b0; continuous = 1'b0; sel = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("por_a");
        sel = 1'b1; #1;
        check_reset_outputs("por_b");
        sel = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;

        for (int r = 0; r < 5; r++) begin
            run_frame(tbl[r].s, tbl[r].l, tbl[r].rr, tbl[r].cont, tbl[r].frames);
            check("writes", 64'(wr_cnt), 64'(tbl[r].exp_writes));
            check("done_pulses", 64'(done_cnt), 64'(tbl[r].exp_done));
            check("latch_pulses", 64'(latch_cnt), 64'(tbl[r].exp_done));
            check("seq_err_end", 64'(s_err), 64'(0));
            check("inflight_end", 64'(s_infl), 64'(0));
            if (tbl[r].exact) check("peak_inflight", 64'(peak), 64'(tbl[r].exp_peak));
            else              check("peak_bound", 64'(peak <= tbl[r].exp_peak), 64'(1));
        end

        // Out-of-order tag: expected (1,0), renderer reports (2,0)
        bad_tag_en = 1'b1;
        run_frame(1'b0, 5, 1'b0, 1'b0, 1);
        bad_tag_en = 1'b0;
        check("badtag_writes", 64'(wr_cnt), 64'(12));
        check("badtag_seq_err", 64'(s_err), 64'(1));
        repeat (5) @(posedge aclk);
        #1;
        check("badtag_sticky", 64'(s_err), 64'(1));

        // Asynchronous reset in the middle of ISSUE with five pixels outstanding
        @(posedge aclk); #1;
        sel = 1'b0; lat = 5; clear_counts();
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        check("err_held_in_latch", 64'(s_err), 64'(1));
        @(posedge aclk); #1;
        check("err_cleared_after_latch", 64'(s_err), 64'(0));
        for (int i = 0; i < 100 && s_infl != 5; i++) begin
            @(posedge aclk); #1;
        end
        check("reach_inflight5", 64'(s_infl), 64'(5));
        aresetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        run_frame(1'b0, 5, 1'b0, 1'b0, 1);
        check("post_rst_writes", 64'(wr_cnt), 64'(12));
        check("post_rst_seq_err", 64'(s_err), 64'(0));
        check("post_rst_done", 64'(done_cnt), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
